// File: rtl/vmem_arbiter.sv
// vmem_arbiter
// Single-port framebuffer arbiter. Scanout reads always win the RAM. Pixel
// writes are queued in a small FIFO and retire on free cycles. A clear-screen
// engine first drains the queue, then fills the whole frame with one colour.
module vmem_arbiter #(
    parameter int              AW        = 19,
    parameter int              DW        = 24,
    parameter int              DEPTH     = 4,
    parameter logic [AW-1:0]   FILL_LAST = {AW{1'b1}}
) (
    input  logic          clk,
    input  logic          rst,
    // scanout read port
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    // buffered pixel-write port
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    // clear-screen engine
    input  logic          fill_start,
    input  logic [DW-1:0] fill_color,
    output logic          fill_busy,
    // framebuffer RAM
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            CW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   FULL_COUNT = (CW+1)'(DEPTH);

    // FSM encoding kept as plain constants for compatibility with older tools
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_entry_t;

    logic [1:0]    state;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_color_q;

    wr_entry_t     fifo_mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW:0]   count;
    wr_entry_t     head;

    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          grant_rd;
    logic          grant_fill;
    logic          grant_fifo;

    // ------------------------------------------------------------------
    // Grant and handshake decode
    // ------------------------------------------------------------------
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

    // Ready looks only at the pre-pop count: a full FIFO stays closed for one
    // cycle even while its head retires, so there is no combinational bypass.
    assign wr_ready   = (count < FULL_COUNT) && (state != ST_FILL);
    assign push       = wr_valid && wr_ready;

    // Fixed priority: scanout, then fill engine, then queued writes.
    assign grant_rd   = rd_req;
    assign grant_fill = !rd_req && (state == ST_FILL);
    assign grant_fifo = !rd_req && (state != ST_FILL) && !fifo_empty;
    assign pop        = grant_fifo;

    assign fill_busy  = (state != ST_IDLE);
    assign rd_data    = mem_rdata;

    // Drive the RAM port from whichever requester holds the grant
    always_comb begin
        // NOTE: every output gets a default before the priority chain so no
        // path through the block leaves a value held, which would infer a latch.
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_rd) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
        end else if (grant_fill) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = fill_addr;
            mem_wdata = fill_color_q;
        end else if (grant_fifo) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = head.addr;
            mem_wdata = head.data;
        end
    end

    // Read data returns one cycle after the request; flag it alongside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            // NOTE: registers are updated with non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            rd_valid <= rd_req;
        end
    end

    // Write FIFO payload storage
    always_ff @(posedge clk) begin
        // NOTE: the payload array has no reset; stale entries are never read
        // because the pointers and count are reset, and skipping the reset lets
        // the array map onto plain RAM/LUT storage.
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: wr_addr, data: wr_data};
        end
    end

    // Write FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Clear-screen sequencer: latch colour, drain queued writes, then sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            fill_addr    <= '0;
            fill_color_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fill_start) begin
                        fill_color_q <= fill_color;
                        state        <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Writes queued before the fill request must land first.
                    if (fifo_empty) begin
                        fill_addr <= '0;
                        state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // A scanout cycle simply holds the counter; nothing skipped.
                    if (grant_fill) begin
                        if (fill_addr == FILL_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            fill_addr <= fill_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter
// Directed scenarios with literal expectations, followed by randomized
// traffic, all checked every cycle against a queue-based reference model.
module tb_vmem_arbiter;

    localparam int              AW        = 6;
    localparam int              DW        = 24;
    localparam int              DEPTH     = 4;
    localparam logic [AW-1:0]   FILL_LAST = 6'd15;
    localparam int              NWORDS    = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_color = '0;
    logic          fill_busy;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    vmem_arbiter #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .FILL_LAST(FILL_LAST)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Framebuffer RAM environment: synchronous read, preloaded data = addr
    // ------------------------------------------------------------------
    logic [DW-1:0] ram [NWORDS];
    initial for (int i = 0; i < NWORDS; i++) ram[i] = DW'(i);

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // ------------------------------------------------------------------
    // Reference model: write queue, fill phase, and a shadow framebuffer
    // ------------------------------------------------------------------
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wlog_t;

    ent_t          m_q[$];
    int            m_mode = 0;        // 0 none, 1 waiting for queue empty, 2 sweeping
    int            m_faddr = 0;
    logic [DW-1:0] m_color = '0;
    bit            m_rv = 0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] m_mem [NWORDS];
    initial for (int i = 0; i < NWORDS; i++) m_mem[i] = DW'(i);

    wlog_t         wlog[$];           // observed RAM writes, for directed checks

    bit            e_ready, e_en, e_we, g_fifo;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    int            qsz;

    always @(negedge clk) begin
        if (mem_en === 1'b1 && mem_we === 1'b1)
            wlog.push_back('{cyc: cyc, addr: mem_addr, data: mem_wdata});
        if (rst) begin
            m_q.delete();
            m_mode  = 0;
            m_faddr = 0;
            m_rv    = 0;
            check("rst_rd_valid",  rd_valid,  1'b0);
            check("rst_fill_busy", fill_busy, 1'b0);
            check("rst_wr_ready",  wr_ready,  1'b1);
            check("rst_mem_we",    mem_we,    1'b0);
            check("rst_mem_en",    mem_en,    rd_req);
        end else begin
            qsz     = m_q.size();
            e_ready = (qsz < DEPTH) && (m_mode != 2);
            e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; g_fifo = 0;
            if (rd_req) begin
                e_en = 1; e_addr = rd_addr;
            end else if (m_mode == 2) begin
                e_en = 1; e_we = 1; e_addr = AW'(m_faddr); e_wdata = m_color;
            end else if (qsz > 0) begin
                e_en = 1; e_we = 1; e_addr = m_q[0].a; e_wdata = m_q[0].d; g_fifo = 1;
            end
            check("wr_ready",  wr_ready,  e_ready);
            check("fill_busy", fill_busy, m_mode != 0);
            check("rd_valid",  rd_valid,  m_rv);
            if (m_rv) check("rd_data", rd_data, m_rdata);
            check("mem_en",    mem_en,    e_en);
            check("mem_we",    mem_we,    e_we);
            check("mem_addr",  mem_addr,  e_addr);
            check("mem_wdata", mem_wdata, e_wdata);
            // advance one clock
            m_rv = rd_req;
            if (rd_req) m_rdata = m_mem[rd_addr];
            if (e_en && e_we) m_mem[e_addr] = e_wdata;
            if (g_fifo) void'(m_q.pop_front());
            if (wr_valid && e_ready) m_q.push_back('{a: wr_addr, d: wr_data});
            case (m_mode)
                0: if (fill_start) begin m_color = fill_color; m_mode = 1; end
                1: if (qsz == 0) begin m_faddr = 0; m_mode = 2; end
                2: if (!rd_req) begin
                       if (m_faddr == int'(FILL_LAST)) m_mode = 0;
                       else m_faddr = m_faddr + 1;
                   end
                default: m_mode = 0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        rd_req = 1'b0; wr_valid = 1'b0; fill_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx, busy, rds, n7;
        bit  done, hit;

        // ---- reset ----
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        check("lit_reset_wr_ready",  wr_ready,  1'b1);
        check("lit_reset_fill_busy", fill_busy, 1'b0);
        check("lit_reset_rd_valid",  rd_valid,  1'b0);
        check("lit_reset_mem_addr",  mem_addr,  '0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // ---- four back-to-back reads, data = address ----
        for (int i = 0; i < 5; i++) begin
            rd_req  = (i < 4);
            rd_addr = AW'(6'h10 + i);
            @(negedge clk);
            check("lit_read_we", mem_we, 1'b0);
            if (i > 0) begin
                check("lit_read_valid", rd_valid, 1'b1);
                check("lit_read_data",  rd_data,  DW'(24'h10 + i - 1));
            end
            tick();
        end
        idle_inputs();
        tick();

        // ---- queue fills behind scanout, then drains ----
        wlog.delete();
        rd_req = 1'b1; rd_addr = 6'h30; idx = 0;
        for (int c = 0; c < 6; c++) begin
            wr_valid = 1'b1;
            wr_addr  = AW'(6'h38 + idx);
            wr_data  = DW'(24'h500000 + idx);
            @(negedge clk);
            if (wr_ready) idx++;
            tick();
        end
        check("lit_accepts_while_read", idx, 4);
        check("lit_no_write_while_read", wlog.size(), 0);
        rd_req = 1'b0;
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            if (r == 0) check("lit_full_ready_r0", wr_ready, 1'b0);
            if (r == 1) check("lit_full_ready_r1", wr_ready, 1'b1);
            tick();
            if (r == 1) wr_valid = 1'b0;
        end
        check("lit_drain_count", wlog.size(), 5);
        for (int k = 0; k < 5 && k < wlog.size(); k++) begin
            check("lit_drain_addr", wlog[k].addr, AW'(6'h38 + k));
            check("lit_drain_data", wlog[k].data, DW'(24'h500000 + k));
            if (k < 4) check("lit_drain_consec", wlog[k].cyc - wlog[0].cyc, k);
        end

        // ---- fill with two queued writes, late fill_start and writes ignored ----
        wlog.delete();
        rd_req = 1'b1; rd_addr = 6'h31;
        wr_valid = 1'b1; wr_addr = 6'h20; wr_data = 24'hAAAAAA;
        tick();
        wr_addr = 6'h21; wr_data = 24'hBBBBBB;
        fill_start = 1'b1; fill_color = 24'hFF0000;
        @(negedge clk);
        check("lit_fill_pulse_busy", fill_busy, 1'b0);
        tick();
        idle_inputs();
        busy = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (!fill_busy) done = 1;
            else begin
                busy++;
                if (wr_valid) check("lit_wr_ready_in_fill", wr_ready, 1'b0);
            end
            tick();
            wr_valid   = (busy >= 5 && busy <= 8);
            wr_addr    = 6'h22;
            fill_start = (busy == 10);
            fill_color = 24'h00FF00;
        end
        idle_inputs();
        check("lit_fill1_done", done, 1'b1);
        check("lit_fill1_busy_cycles", busy, 19);
        check("lit_fill1_writes", wlog.size(), 18);
        if (wlog.size() == 18) begin
            check("lit_fill1_w0", {wlog[0].addr, wlog[0].data}, {6'h20, 24'hAAAAAA});
            check("lit_fill1_w1", {wlog[1].addr, wlog[1].data}, {6'h21, 24'hBBBBBB});
            for (int k = 0; k < 16; k++)
                check("lit_fill1_px", {wlog[k+2].addr, wlog[k+2].data}, {AW'(k), 24'hFF0000});
        end
        for (int c = 0; c < 20; c++) tick();
        check("lit_fill1_single", wlog.size(), 18);

        // ---- fill interleaved with scanout every other cycle ----
        wlog.delete();
        fill_start = 1'b1; fill_color = 24'h123456;
        tick();
        fill_start = 1'b0;
        busy = 0; rds = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!fill_busy) done = 1;
            else begin
                busy++;
                if (busy >= 2 && rd_req) rds++;
            end
            tick();
            rd_req  = ~rd_req;
            rd_addr = AW'($urandom);
        end
        rd_req = 1'b0;
        check("lit_fill2_done", done, 1'b1);
        check("lit_fill2_reads_seen", rds >= 7, 1'b1);
        check("lit_fill2_busy_cycles", busy, 17 + rds);
        check("lit_fill2_writes", wlog.size(), 16);
        for (int k = 0; k < 16 && k < wlog.size(); k++)
            check("lit_fill2_px", {wlog[k].addr, wlog[k].data}, {AW'(k), 24'h123456});
        tick();

        // ---- reset aborts a fill about to write address 7 ----
        wlog.delete();
        fill_start = 1'b1; fill_color = 24'h0F0F0F;
        tick();
        fill_start = 1'b0;
        hit = 0;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge clk);
            if (mem_we && mem_addr == 6'd6) hit = 1;
            tick();
        end
        check("lit_abort_reached", hit, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("lit_abort_busy",  fill_busy, 1'b0);
        check("lit_abort_ready", wr_ready,  1'b1);
        check("lit_abort_we",    mem_we,    1'b0);
        n7 = wlog.size();
        check("lit_abort_writes_before", n7, 7);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 30; c++) tick();
        check("lit_abort_no_more_writes", wlog.size(), n7);

        // ---- randomized traffic ----
        for (int c = 0; c < 3000; c++) begin
            rd_req     = ($urandom_range(0, 1) == 1);
            rd_addr    = AW'($urandom);
            wr_valid   = ($urandom_range(0, 9) < 4);
            wr_addr    = AW'($urandom);
            wr_data    = DW'($urandom);
            fill_start = ($urandom_range(0, 199) == 0);
            fill_color = DW'($urandom);
            rst        = ($urandom_range(0, 1499) == 0);
            tick();
        end
        idle_inputs();
        rst = 1'b0;
        for (int c = 0; c < 60; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vmem_arbiter.md
# vmem_arbiter

Single-port video-memory arbiter and sequencer. Shares one synchronous-read framebuffer RAM between three requesters: VGA scanout reads, a write port from the drawing/keyboard logic, and a built-in clear-screen fill engine. It sits between `vga_ctrl`/pixel-write logic and the framebuffer RAM. Scanout always wins, and writes are buffered so that scanout never stalls.

## Interface
Parameters:
- `AW`, 19: memory address width (`{h_addr[9:0], v_addr[8:0]}`)
- `DW`, 24: pixel width (RGB888)
- `DEPTH`, 4: write FIFO entries (power of two, ≥2)
- `FILL_LAST`, 2^AW−1: last address written by a fill

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `rd_req`  in  1  scanout read request this cycle
- `rd_addr`  in  AW  scanout read address
- `rd_valid`  out  1  `rd_data` valid; `rd_req` delayed one cycle
- `rd_data`  out  DW  read data; equals `mem_rdata`; meaningful only when `rd_valid`=1
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  FIFO can accept; transfer when `wr_valid`&`wr_ready`
- `wr_addr`  in  AW  write address
- `wr_data`  in  DW  write pixel
- `fill_start`  in  1  single-cycle pulse: clear the frame to `fill_color`
- `fill_color`  in  DW  sampled on an accepted `fill_start`
- `fill_busy`  out  1  a fill is pending or running
- `mem_en`  out  1  RAM access this cycle
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  AW  RAM address
- `mem_wdata`  out  DW  RAM write data
- `mem_rdata`  in  DW  RAM read data, valid one cycle after a read

## Operation
- Grant priority, evaluated each cycle: scanout read > fill write (state FILL) > FIFO head write > idle.
- Memory outputs are combinational from the grant:
  - Read grant: `mem_en`=1, `mem_we`=0, `mem_addr`=`rd_addr`.
  - Write grant: `mem_en`=1, `mem_we`=1, address and data taken from the fill counter or the FIFO head.
  - Idle: all memory outputs 0.
- The FIFO head is popped only in a cycle where it is granted.
- Write FIFO:
  - `wr_ready` = (count < `DEPTH`) && state ≠ FILL.
  - A push and a pop in the same cycle leave count unchanged.
  - `wr_ready` is based on count before any pop; there is no bypass path.
- State machine:
  - IDLE: an accepted `fill_start` latches `fill_color` and moves to DRAIN.
  - DRAIN: FIFO drains normally. When count == 0, clear the fill counter and go to FILL.
  - FILL: each cycle without `rd_req`, write `fill_color` at `fill_addr` and increment. After writing `FILL_LAST`, return to IDLE. The counter never wraps past `FILL_LAST`.
- `fill_busy` = (state ≠ IDLE).
- `fill_start` is ignored while `fill_busy`=1.
- A write accepted in the same cycle as `fill_start` is enqueued first and lands before the fill.
- `rd_req` during FILL holds `fill_addr` for that cycle; the fill resumes on the next free cycle.
- A write to the address being scanned out in the same cycle is deferred, so the read returns the old pixel.

## Timing
- Reset values:
  - State IDLE, FIFO count 0, fill counter 0, `rd_valid`=0, `fill_busy`=0, `wr_ready`=1.
  - `mem_en`/`mem_we`/`mem_addr`/`mem_wdata` are 0 while `rd_req`=0.
- Read latency is 1 cycle: `rd_req` at cycle N gives `rd_valid`=1 and `rd_data` at N+1. Back-to-back reads are sustained every cycle.
- Write latency: an accepted write reaches the RAM at the earliest cycle after acceptance in which the arbiter has no read and no fill.
- Fill duration: `FILL_LAST`+1 write cycles plus the number of `rd_req` cycles during FILL. `fill_busy` falls the cycle after the `FILL_LAST` write.
- Reset asserted mid-fill or mid-drain aborts the operation immediately. The FIFO is emptied and pending writes are lost.

## Test plan
- Reset, then `rd_req`=1 for 4 cycles at addresses 0x00010..0x00013 with RAM preloaded as data = address → `rd_valid`=1 on cycles 2–5, `rd_data` = 0x000010..0x000013, `mem_we`=0 throughout.
- Push 5 writes with `rd_req` held at 1 → `wr_ready` drops after 4 accepts, no `mem_we` occurs. Release `rd_req` → 4 writes retire on 4 consecutive cycles in order, then the 5th write is accepted.
- `FILL_LAST`=15, push 2 writes, `fill_start` with color 0xFF0000 in the same cycle as the 2nd write → both writes retire, then addresses 0..15 are written with 0xFF0000. `fill_busy` lasts 2+16 cycles plus 1 cycle of DRAIN exit.
- During that fill, toggle `rd_req` every other cycle → every read is served with latency 1, the fill takes 16 write cycles, and no address is skipped or repeated.
- Pulse `fill_start` while `fill_busy`=1 → ignored, only one fill occurs. `wr_valid` asserted during FILL → `wr_ready`=0 until FILL ends.
- Assert `rst` at fill address 7 → next cycle `fill_busy`=0, `wr_ready`=1, no further `mem_we`.
